// File: rtl/multi_cycle_shifter_pkg.sv
// multi_cycle_shifter_pkg: shared state encoding and direction constants
package multi_cycle_shifter_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/multi_cycle_shifter_shift_by_one.sv
// shift_by_one: single-bit left / logical-right / arithmetic-right shift step
module shift_by_one
  import multi_cycle_shifter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] data,
  input  logic         dir,
  input  logic         arith,
  output logic [N-1:0] data_next
);
  // left fills 0 at the LSB; right fills the sign bit only when arithmetic
  always_comb
    data_next = (dir == DIR_LEFT) ? {data[N-2:0], 1'b0} : {arith & data[N-1], data[N-1:1]};
endmodule

// File: rtl/multi_cycle_shifter.sv
// multi_cycle_shifter: handshaked variable-amount shifter, one bit per clock
module multi_cycle_shifter
  import multi_cycle_shifter_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arg_vld,
  output logic         arg_rdy,
  input  logic [N-1:0] arg_data,
  input  logic [W-1:0] arg_shamt,
  input  logic         arg_dir,
  input  logic         arg_arith,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [N-1:0] res_data,
  output logic         busy
);
  state_t       state_q, state_d;
  logic [N-1:0] data_q, data_d, data_sh;
  logic [W-1:0] cnt_q, cnt_d;
  logic         dir_q, dir_d, arith_q, arith_d;

  shift_by_one #(.N(N)) u_step (
    .data     (data_q),
    .dir      (dir_q),
    .arith    (arith_q),
    .data_next(data_sh)
  );

  // state and datapath registers, cleared asynchronously so an abort is immediate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

  // accept in IDLE, step once per edge in SHIFT, hold the result in DONE until taken
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    case (state_q)
      IDLE: if (arg_vld) begin
        data_d  = arg_data;
        cnt_d   = arg_shamt;
        dir_d   = arg_dir;
        arith_d = arg_arith;
        state_d = (arg_shamt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        data_d  = data_sh;
        cnt_d   = cnt_q - W'(1);
        state_d = (cnt_q == W'(1)) ? DONE : SHIFT;
      end
      DONE: state_d = res_rdy ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  assign arg_rdy  = (state_q == IDLE);
  assign res_vld  = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign res_data = data_q;
endmodule
